// File: rtl/seven_segment_scanner_pkg.sv
// Shared constants for the seven-segment scanner: glyph table,
// segment bit positions and a helper for index widths.
package seven_seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high segments, bit 0 = a ... bit 6 = g; glyphs 0-9, A b C d E F.
    localparam logic [0:15][6:0] HEX_SEG = {
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Bits needed to hold 0..n-1; never less than one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_segment_scanner_decoder.sv
// Combinational hex nibble to active-high segment pattern.
// One instance decodes whichever digit the scanner has selected.
module seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup of the glyph for this nibble
    always_comb begin
        seg_o = HEX_SEG[nibble_i];
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit hex display driver with dp, blanking and PWM.
// Define SEVEN_SEG_LZ_SUPPRESS_EN to enable leading-zero suppression.
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_CYCLES = 10000,
    parameter int PWM_BITS       = 4,
    parameter int ACTIVE_LOW     = 1
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              cathode,
    output logic                    frame_tick
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int RW = idx_width(REFRESH_CYCLES);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [RW-1:0] LAST_CNT = RW'(REFRESH_CYCLES - 1);

    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW != 0}};
    localparam logic [7:0]            CAT_OFF = {8{ACTIVE_LOW != 0}};

    logic [RW-1:0]         refresh_cnt_q, refresh_cnt_d;
    logic [IW-1:0]         digit_idx_q, digit_idx_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q;
    logic                  wrap_q, wrap_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [7:0]            cathode_q, cathode_d;
    logic                  frame_tick_q;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic [NUM_DIGITS-1:0] blank_eff;
    logic [NUM_DIGITS-1:0] onehot;
    logic [7:0]            cat_hi;
    logic [3:0]            nibble;
    logic [6:0]            seg;
    logic                  pwm_on;
    logic                  driven;

    // Slot timer and digit index; flags the last-to-first digit wrap
    always_comb begin
        refresh_cnt_d = refresh_cnt_q + 1'b1;
        digit_idx_d   = digit_idx_q;
        wrap_d        = 1'b0;
        if (refresh_cnt_q == LAST_CNT) begin
            refresh_cnt_d = '0;
            if (digit_idx_q == LAST_IDX) begin
                digit_idx_d = '0;
                wrap_d      = 1'b1;
            end else begin
                digit_idx_d = digit_idx_q + 1'b1;
            end
        end
    end

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
    // Dark every zero digit above the top nonzero one, except dp digits
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run & (value[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run & ~dp[i];
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign blank_eff = blank | lz_mask;
    assign nibble    = value[4*int'(digit_idx_q) +: 4];
    assign pwm_on    = (&brightness) | (pwm_cnt_q < brightness);
    assign driven    = pwm_on & ~blank_eff[digit_idx_q];

    seg_hex_decoder u_dec (
        .nibble_i (nibble),
        .seg_o    (seg)
    );

    // Build pins in active-high form, then fold in board polarity
    always_comb begin
        onehot              = '0;
        onehot[digit_idx_q] = 1'b1;
        cat_hi              = '0;
        cat_hi[SEG_G:SEG_A] = seg;
        cat_hi[SEG_DP]      = dp[digit_idx_q];
        anode_d             = AN_OFF;
        cathode_d           = CAT_OFF;
        if (driven) begin
            anode_d   = onehot ^ AN_OFF;
            cathode_d = cat_hi ^ CAT_OFF;
        end
    end

    // Counters and output registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt_q <= '0;
            digit_idx_q   <= '0;
            pwm_cnt_q     <= '0;
            wrap_q        <= 1'b0;
            anode_q       <= AN_OFF;
            cathode_q     <= CAT_OFF;
            frame_tick_q  <= 1'b0;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
            pwm_cnt_q     <= pwm_cnt_q + 1'b1;
            wrap_q        <= wrap_d;
            anode_q       <= anode_d;
            cathode_q     <= cathode_d;
            frame_tick_q  <= wrap_q;
        end
    end

    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign frame_tick = frame_tick_q;

endmodule
